line_fill_memory: RTL and testbench
===================================

Name: line_fill_memory

Overview:
- Main-memory model and controller directly downstream of the L1 cache.
- Serves cache-line refills as fixed-length word bursts, requested by an active-low MRd.
- Accepts write-through stores from the cache through a one-entry posted write buffer.
- Replaces ad-hoc memory stubs on the cache's memory side and gives refill timing a defined protocol.

Parameters:
- ADDR_W, 12, word-index bits; storage depth is 2**ADDR_W 32-bit words.
- LINE_WORDS, 4, beats per refill burst; must be a power of two, 2..16.
- RD_LATENCY, 2, wait cycles between request capture and the first beat; range 1..15.

Ports:
- CLK  in  1  single system clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- MRd  in  1  refill request, active low; the cache holds it low until the burst ends.
- MWr  in  1  write-through strobe, active high, sampled each cycle.
- MA  in  32  byte address; word index = MA[ADDR_W+1:2]; line base clears the low log2(LINE_WORDS) word bits.
- MD_in  in  32  write data, valid with MWr.
- MD_out  out  32  burst beat data.
- MD_valid  out  1  MD_out holds a valid beat this cycle.
- MBusy  out  1  high from refill capture until the cycle after the last beat.
- WBFull  out  1  posted write buffer occupied.
- Err  out  1  sticky overflow flag: a write was dropped.

Behaviour:
- Reset (async, RST_N low):
  - MD_out=0, MD_valid=0, MBusy=0, WBFull=0, Err=0.
  - FSM goes to IDLE; beat and latency counters go to 0.
  - Write buffer is invalidated; armed flag is set to 1.
  - Storage array is not cleared.
  - Reset mid-burst aborts the burst with no further beats.
- FSM states: IDLE, DRAIN, WAIT, BURST.
- IDLE:
  - Buffered write pending -> DRAIN. Buffered writes always retire before a new refill reads the array.
  - Else if MWr=1, write MD_in to the array directly in the same cycle.
  - Else if MRd=0 and armed=1: capture the line base from MA, set MBusy=1, clear armed, go to WAIT.
  - MWr=1 and MRd=0 in the same IDLE cycle: the write executes first; the refill is captured the next cycle (MBusy rises one cycle later).
- DRAIN: write the buffer entry to the array, clear WBFull, return to IDLE (1 cycle).
- WAIT: count RD_LATENCY cycles, then go to BURST.
- BURST:
  - Emit LINE_WORDS beats on consecutive cycles, MD_valid=1, word order base+0 upward (no critical-word-first).
  - First beat appears RD_LATENCY+1 cycles after the capture edge.
  - After the last beat: MD_valid=0, MBusy=0, return to IDLE.
- Armed flag:
  - Set whenever MRd is sampled high; re-arms the requester.
  - A MRd held low past burst end must not start a second burst.
  - MRd rising during WAIT/BURST does not abort; the burst completes.
- Writes during WAIT/BURST:
  - Posted into the buffer (address + data), WBFull=1.
  - MWr while WBFull=1 is dropped and sets Err; Err stays set until reset.
- Forwarding: if the buffered write's word index equals a not-yet-emitted beat of the current line, that beat returns the buffered data. The array is still updated in DRAIN.
- Address arithmetic:
  - MA bits above ADDR_W+1 are ignored, so addresses alias modulo memory size.
  - The beat counter wraps within the line; it never crosses the line base.
- Array read is synchronous; MD_out is registered.
- MD_out holds its last beat value when MD_valid=0.

Test Plan:
- Reset, preload words 0x40..0x4C = 1,2,3,4; MA=0x44, MRd low -> MBusy next edge; beats 1,2,3,4 (line base 0x40) on cycles 3..6 after capture; MBusy low after beat 4.
- MRd held low for 20 cycles after the burst -> exactly one burst; toggle MRd high one cycle, low again -> second burst.
- Same-cycle MWr=1 (MA=0x48, data 0xDEAD) and MRd=0 (MA=0x40) -> write first; burst beat 2 = 0xDEAD; MBusy rises one cycle later than the solo case.
- MWr to 0x4C (0xBEEF) during WAIT -> WBFull=1; beat 3 = 0xBEEF (forwarded); DRAIN after the burst; a later refill also returns 0xBEEF.
- Two MWr during one burst -> second dropped, Err=1 and sticky, array holds only the first write.
- RST_N low during beat 2 -> MD_valid, MBusy, WBFull drop asynchronously; no beats after release until a new MRd falling request.

Source files
------------

// File: rtl/line_fill_memory_if.sv
// Cache-to-memory bus: refill request/burst return and write-through stores.
interface line_fill_memory_if;
    logic        MRd;       // refill request, active low
    logic        MWr;       // write-through strobe
    logic [31:0] MA;        // byte address
    logic [31:0] MD_in;     // write data
    logic [31:0] MD_out;    // burst beat data
    logic        MD_valid;  // MD_out carries a beat this cycle
    logic        MBusy;     // refill in progress
    logic        WBFull;    // posted write buffer occupied
    logic        Err;       // sticky: a write was dropped

    // Cache side drives requests and stores.
    modport master (
        output MRd, MWr, MA, MD_in,
        input  MD_out, MD_valid, MBusy, WBFull, Err
    );

    // Memory side serves them.
    modport slave (
        input  MRd, MWr, MA, MD_in,
        output MD_out, MD_valid, MBusy, WBFull, Err
    );
endinterface

// File: rtl/line_fill_memory.sv
// Main-memory model and refill controller behind the L1 cache.
// Refills are fixed-length bursts starting at the line base; stores issued while a refill
// is in flight are posted into a one-entry buffer that retires before the next refill.
module line_fill_memory #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input logic               CLK,
    input logic               RST_N,
    line_fill_memory_if.slave bus
);

    localparam int unsigned    LwBits  = $clog2(LINE_WORDS);
    localparam int unsigned    LineW   = ADDR_W - LwBits;
    localparam logic [3:0]     LatLast = 4'(RD_LATENCY - 1);
    localparam logic [LwBits:0] BeatEnd = (LwBits + 1)'(LINE_WORDS);

    typedef enum logic [1:0] {StIdle, StDrain, StWait, StBurst} state_e;

    state_e              state_q;
    logic [3:0]          lat_q;
    logic [LwBits:0]     beat_q;     // extra MSB marks "all beats emitted"
    logic [LineW-1:0]    base_q;     // captured line index
    logic                armed_q;
    logic                wb_valid_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [31:0]         wb_data_q;
    logic                err_q;
    logic [31:0]         md_out_q;
    logic                md_valid_q;
    logic                mbusy_q;

    logic [31:0]         mem_q [2**ADDR_W];
    logic [31:0]         ram_q;      // synchronous read data, one beat ahead of MD_out

    logic [ADDR_W-1:0]   ma_idx;
    logic [ADDR_W-1:0]   beat_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic [LwBits-1:0]   rd_beat;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [31:0]         mem_wdata;
    logic                wr_post;
    logic                wr_drop;
    logic                unused_ma;

    // Upper address bits alias modulo memory size; byte offset is ignored.
    assign ma_idx    = bus.MA[ADDR_W+1:2];
    assign unused_ma = ^{bus.MA[31:ADDR_W+2], bus.MA[1:0]};

    assign beat_idx = {base_q, beat_q[LwBits-1:0]};
    assign rd_idx   = {base_q, rd_beat};

    // A full buffer drops any further store; only WAIT/BURST post into it.
    assign wr_drop = bus.MWr && wb_valid_q;
    assign wr_post = bus.MWr && !wb_valid_q && (state_q == StWait || state_q == StBurst);

    // Prefetch address: the array read leads the beat register by one cycle, so the last
    // WAIT cycle fetches beat 0 and each BURST cycle fetches the following beat.
    always_comb begin
        rd_beat = '0;
        if (state_q == StBurst) begin
            rd_beat = beat_q[LwBits-1:0] + 1'b1;
        end
    end

    // Array write port: buffer drain, or a direct store while idle with nothing pending.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ma_idx;
        mem_wdata = bus.MD_in;
        if (state_q == StDrain) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr_q;
            mem_wdata = wb_data_q;
        end else if (state_q == StIdle && !wb_valid_q && bus.MWr) begin
            mem_we = 1'b1;
        end
    end

    // Storage array with synchronous read; never reset. The array is only written in
    // IDLE/DRAIN, so the prefetched word is never stale during a burst.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        ram_q <= mem_q[rd_idx];
    end

    // Controller FSM with registered outputs, posted write buffer and re-arm tracking.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            lat_q      <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            armed_q    <= 1'b1;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
            md_out_q   <= '0;
            md_valid_q <= 1'b0;
            mbusy_q    <= 1'b0;
        end else begin
            // Seeing MRd high re-arms the requester; a held-low MRd never retriggers.
            if (bus.MRd) begin
                armed_q <= 1'b1;
            end
            if (wr_drop) begin
                err_q <= 1'b1;
            end
            if (wr_post) begin
                wb_valid_q <= 1'b1;
                wb_addr_q  <= ma_idx;
                wb_data_q  <= bus.MD_in;
            end

            unique case (state_q)
                StIdle: begin
                    if (wb_valid_q) begin
                        state_q <= StDrain;
                    end else if (bus.MWr) begin
                        // Direct store handled by the array write port; refill waits a cycle.
                    end else if (!bus.MRd && armed_q) begin
                        base_q  <= ma_idx[ADDR_W-1:LwBits];
                        mbusy_q <= 1'b1;
                        armed_q <= 1'b0;
                        lat_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StDrain: begin
                    wb_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
                StWait: begin
                    if (lat_q == LatLast) begin
                        beat_q  <= '0;
                        state_q <= StBurst;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                StBurst: begin
                    if (beat_q == BeatEnd) begin
                        md_valid_q <= 1'b0;
                        mbusy_q    <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        // A pending store to this beat's word wins over the array.
                        if (wb_valid_q && wb_addr_q == beat_idx) begin
                            md_out_q <= wb_data_q;
                        end else begin
                            md_out_q <= ram_q;
                        end
                        md_valid_q <= 1'b1;
                        beat_q     <= beat_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.MD_out   = md_out_q;
    assign bus.MD_valid = md_valid_q;
    assign bus.MBusy    = mbusy_q;
    assign bus.WBFull   = wb_valid_q;
    assign bus.Err      = err_q;

endmodule

// File: tb/tb_line_fill_memory.sv
// Directed bench for line_fill_memory: vector tables for the refill/forwarding scenarios,
// hand-written sequences for the held request, re-arm and mid-burst reset.
module tb_line_fill_memory;

    logic clk;
    logic rst_n;

    line_fill_memory_if bus ();

    line_fill_memory #(
        .ADDR_W    (12),
        .LINE_WORDS(4),
        .RD_LATENCY(2)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mrd;
        logic        mwr;
        logic [31:0] ma;
        logic [31:0] din;
        logic        ev;
        logic [31:0] ed;
        logic        eb;
        logic        ew;
        logic        ee;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic drive(input logic mrd, input logic mwr, input logic [31:0] ma,
                         input logic [31:0] din);
        bus.MRd   = mrd;
        bus.MWr   = mwr;
        bus.MA    = ma;
        bus.MD_in = din;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic ev, input logic [31:0] ed, input logic eb,
                         input logic ew, input logic ee);
        n_vec++;
        if (bus.MD_valid !== ev || bus.MD_out !== ed || bus.MBusy !== eb ||
            bus.WBFull !== ew || bus.Err !== ee) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b data=%08h busy=%0b wbfull=%0b err=%0b, expected valid=%0b data=%08h busy=%0b wbfull=%0b err=%0b",
                     n, bus.MD_valid, bus.MD_out, bus.MBusy, bus.WBFull, bus.Err,
                     ev, ed, eb, ew, ee);
        end
    endtask

    task automatic add(input string n, input logic mrd, input logic mwr, input logic [31:0] ma,
                       input logic [31:0] din, input logic ev, input logic [31:0] ed,
                       input logic eb, input logic ew, input logic ee);
        vec_t v;
        v.name = n; v.mrd = mrd; v.mwr = mwr; v.ma = ma; v.din = din;
        v.ev = ev; v.ed = ed; v.eb = eb; v.ew = ew; v.ee = ee;
        vecs.push_back(v);
    endtask

    // Capture, two latency cycles, four beats, burst end (RD_LATENCY=2, LINE_WORDS=4).
    task automatic add_refill(input string t, input logic [31:0] ma, input logic [31:0] prev,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic ew, input logic ee);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        add({t, "_cap"}, 1'b0, 1'b0, ma, 0, 1'b0, prev, 1'b1, ew, ee);
        add({t, "_lat1"}, 1'b0, 1'b0, ma, 0, 1'b0, prev, 1'b1, ew, ee);
        add({t, "_lat2"}, 1'b0, 1'b0, ma, 0, 1'b0, prev, 1'b1, ew, ee);
        for (int k = 0; k < 4; k++) begin
            add($sformatf("%s_beat%0d", t, k), 1'b0, 1'b0, ma, 0, 1'b1, d[k], 1'b1, ew, ee);
        end
        add({t, "_end"}, 1'b0, 1'b0, ma, 0, 1'b0, d3, 1'b0, ew, ee);
    endtask

    task automatic run_refill(input string t, input logic [31:0] ma, input logic [31:0] prev,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic ew, input logic ee);
        add_refill(t, ma, prev, d0, d1, d2, d3, ew, ee);
        run_table();
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            drive(vecs[i].mrd, vecs[i].mwr, vecs[i].ma, vecs[i].din);
            step();
            check(vecs[i].name, vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].ew, vecs[i].ee);
        end
        vecs.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        step();
        step();
        check("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Preload line 0x40 with direct stores, then a refill requested mid-line.
        add("pre0", 1'b1, 1'b1, 32'h40, 32'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        add("pre1", 1'b1, 1'b1, 32'h44, 32'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        add("pre2", 1'b1, 1'b1, 32'h48, 32'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        add("pre3", 1'b1, 1'b1, 32'h4C, 32'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        add_refill("b1", 32'h44, 32'h0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0);
        run_table();

        // MRd held low past the burst must not start another one.
        drive(1'b0, 1'b0, 32'h44, 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("hold%0d", i), 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 32'h44, 32'h0);
        step();
        check("rearm", 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        run_refill("b2", 32'h44, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0);

        // Store and request together: store first, capture one cycle later.
        add("s3_arm", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        add("s3_wr_rd", 1'b0, 1'b1, 32'h48, 32'hDEAD, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        add_refill("s3", 32'h40, 32'd4, 32'd1, 32'd2, 32'hDEAD, 32'd4, 1'b0, 1'b0);

        // Store posted during WAIT, forwarded to its beat, drained after the burst.
        add("s4_arm", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        add("s4_cap", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'd4, 1'b1, 1'b0, 1'b0);
        add("s4_post", 1'b0, 1'b1, 32'h4C, 32'hBEEF, 1'b0, 32'd4, 1'b1, 1'b1, 1'b0);
        add("s4_lat2", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'd4, 1'b1, 1'b1, 1'b0);
        add("s4_beat0", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0);
        add("s4_beat1", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0);
        add("s4_beat2", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
        add("s4_beat3_fwd", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b0);
        add("s4_end", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        add("s4_to_drain", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        add("s4_drained", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        add("s4_arm2", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        add_refill("s4r", 32'h40, 32'hBEEF, 32'd1, 32'd2, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);

        // Two stores in one burst: second dropped, Err sticky, array keeps only the first.
        add("s5_arm", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        add("s5_cap", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        add("s5_wr1", 1'b0, 1'b1, 32'h40, 32'h1111, 1'b0, 32'hBEEF, 1'b1, 1'b1, 1'b0);
        add("s5_lat2", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b1, 1'b1, 1'b0);
        add("s5_wr2_drop", 1'b0, 1'b1, 32'h44, 32'h2222, 1'b1, 32'h1111, 1'b1, 1'b1, 1'b1);
        add("s5_beat1", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b1);
        add("s5_beat2", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1);
        add("s5_beat3", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b1);
        add("s5_end", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b1, 1'b1);
        add("s5_to_drain", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b1, 1'b1);
        add("s5_drained", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b1);
        add("s5_arm2", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b1);
        add_refill("s5r", 32'h40, 32'hBEEF, 32'h1111, 32'd2, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1);
        run_table();

        // Reset during beat 2 with a store still buffered.
        add("s6_arm", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b1);
        add("s6_cap", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b1, 1'b0, 1'b1);
        add("s6_post", 1'b0, 1'b1, 32'h48, 32'h5555, 1'b0, 32'hBEEF, 1'b1, 1'b1, 1'b1);
        add("s6_lat2", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hBEEF, 1'b1, 1'b1, 1'b1);
        add("s6_beat0", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h1111, 1'b1, 1'b1, 1'b1);
        add("s6_beat1", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b1);
        run_table();
        #2;
        rst_n  = 1'b0;
        bus.MRd = 1'b1;
        #1;
        check("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("rst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_rst%0d", i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        // Array survives reset; the aborted buffered store never reached it.
        run_refill("s6r", 32'h40, 32'h0, 32'h1111, 32'd2, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
